// File: rtl/mvm_ctrl.sv
// rtl/mvm_ctrl.sv - matrix-vector multiply sequencer: address stepping, aligned tag pipe, result row tagging
// Optional perf_cycles counter enabled by defining MVM_CTRL_PERF_EN.
module mvm_ctrl #(
  parameter int ROWW      = 8,
  parameter int CHUNKW    = 8,
  parameter int MAT_ADDRW = 16,
  parameter int PIPE_LAT  = 4
) (
  input  logic                 clk,
`ifdef MVM_CTRL_PERF_EN
  output logic [31:0]          perf_cycles,
`endif
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWW-1:0]      num_rows,
  input  logic [CHUNKW-1:0]    num_chunks,
  output logic                 busy,
  output logic                 done,
  output logic [CHUNKW-1:0]    vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 acc_ivalid,
  output logic                 acc_first,
  output logic                 acc_last,
  input  logic                 acc_ovalid,
  output logic [ROWW-1:0]      res_row,
  output logic                 res_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ROWW-1:0]       rows_q, rows_d;
  logic [CHUNKW-1:0]     chunks_q, chunks_d;
  logic [CHUNKW-1:0]     vec_raddr_q, vec_raddr_d;
  logic [MAT_ADDRW-1:0]  mat_raddr_q, mat_raddr_d;
  logic [ROWW-1:0]       row_iss_q, row_iss_d;
  logic [ROWW-1:0]       res_cnt_q, res_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PIPE_LAT-1:0]   pv_q, pv_d;
  logic [PIPE_LAT-1:0]   pf_q, pf_d;
  logic [PIPE_LAT-1:0]   pl_q, pl_d;
`ifdef MVM_CTRL_PERF_EN
  logic [31:0]           perf_q, perf_d;
`endif

  logic iss_v, iss_f, iss_l, count_en;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    chunks_d    = chunks_q;
    vec_raddr_d = vec_raddr_q;
    mat_raddr_d = mat_raddr_q;
    row_iss_d   = row_iss_q;
    res_cnt_d   = res_cnt_q;

    iss_v    = (state_q == S_ISSUE);
    iss_f    = (vec_raddr_q == '0);
    iss_l    = (vec_raddr_q == chunks_q - CHUNKW'(1));
    count_en = acc_ovalid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

    if (count_en) res_cnt_d = res_cnt_q + ROWW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d      = num_rows;
          chunks_d    = num_chunks;
          vec_raddr_d = '0;
          mat_raddr_d = '0;
          row_iss_d   = '0;
          res_cnt_d   = '0;
          state_d     = (num_rows == '0 || num_chunks == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Addresses hold on the final issue so DRAIN shows the last address used.
        if (iss_l && (row_iss_q == rows_q - ROWW'(1))) begin
          state_d = S_DRAIN;
        end else begin
          mat_raddr_d = mat_raddr_q + MAT_ADDRW'(1);
          if (iss_l) begin
            vec_raddr_d = '0;
            row_iss_d   = row_iss_q + ROWW'(1);
          end else begin
            vec_raddr_d = vec_raddr_q + CHUNKW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (res_cnt_d == rows_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    pv_d[0] = iss_v;
    pf_d[0] = iss_v & iss_f;
    pl_d[0] = iss_v & iss_l;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pf_d[i] = pf_q[i-1];
      pl_d[i] = pl_q[i-1];
    end

`ifdef MVM_CTRL_PERF_EN
    perf_d = perf_q;
    if (state_q == S_IDLE && start) perf_d = '0;
    else if (busy_q && perf_q != '1) perf_d = perf_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      chunks_q    <= '0;
      vec_raddr_q <= '0;
      mat_raddr_q <= '0;
      row_iss_q   <= '0;
      res_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pv_q        <= '0;
      pf_q        <= '0;
      pl_q        <= '0;
`ifdef MVM_CTRL_PERF_EN
      perf_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      chunks_q    <= chunks_d;
      vec_raddr_q <= vec_raddr_d;
      mat_raddr_q <= mat_raddr_d;
      row_iss_q   <= row_iss_d;
      res_cnt_q   <= res_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pv_q        <= pv_d;
      pf_q        <= pf_d;
      pl_q        <= pl_d;
`ifdef MVM_CTRL_PERF_EN
      perf_q      <= perf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vec_raddr  = vec_raddr_q;
  assign mat_raddr  = mat_raddr_q;
  assign acc_ivalid = pv_q[PIPE_LAT-1];
  assign acc_first  = pf_q[PIPE_LAT-1];
  assign acc_last   = pl_q[PIPE_LAT-1];
  assign res_row    = res_cnt_q;
  assign res_valid  = count_en;
`ifdef MVM_CTRL_PERF_EN
  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mvm_ctrl.sv
// tb/tb_mvm_ctrl.sv - self-checking bench for mvm_ctrl against a cycle-indexed reference model
module tb_mvm_ctrl;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst, start, acc_ovalid;
  logic [7:0]  num_rows, num_chunks;
  logic        busy, done, acc_ivalid, acc_first, acc_last, res_valid;
  logic [7:0]  vec_raddr, res_row;
  logic [15:0] mat_raddr;
`ifdef MVM_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int ov_c[256];
  int n_ov;

  mvm_ctrl #(.ROWW(8), .CHUNKW(8), .MAT_ADDRW(16), .PIPE_LAT(LAT)) dut (
    .clk(clk),
`ifdef MVM_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .rst(rst), .start(start), .num_rows(num_rows), .num_chunks(num_chunks),
    .busy(busy), .done(done), .vec_raddr(vec_raddr), .mat_raddr(mat_raddr),
    .acc_ivalid(acc_ivalid), .acc_first(acc_first), .acc_last(acc_last),
    .acc_ovalid(acc_ovalid), .res_row(res_row), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ivalid"}, 32'(acc_ivalid), 0);
    chk({tag, "_first"}, 32'(acc_first), 0);
    chk({tag, "_last"}, 32'(acc_last), 0);
    chk({tag, "_vec"}, 32'(vec_raddr), 0);
    chk({tag, "_mat"}, 32'(mat_raddr), 0);
    chk({tag, "_row"}, 32'(res_row), 0);
    chk({tag, "_rvalid"}, 32'(res_valid), 0);
  endtask

  // Cycle 0 is the start cycle; issue k (1..r*ch) appears on the address bus in cycle k
  // and on the accumulator tags in cycle k+LAT. Row i's result is returned after its last beat.
  task automatic run(input int r, input int ch, input bit rnd_dly, input bit noise, input int abort);
    int rc, done_c, last_c, ovi, prev, k;
    bit ov, iv;
    rc = r * ch;
    n_ov = 0;
    prev = 0;
    ovi = 0;
    if (r == 0 || ch == 0) begin
      done_c = 1;
    end else begin
      for (int i = 0; i < r; i++) begin
        int t;
        t = (i + 1) * ch + LAT + (rnd_dly ? int'($urandom_range(1, 3)) : 1);
        if (t <= prev) t = prev + 1;
        ov_c[i] = t;
        prev = t;
      end
      n_ov = r;
      done_c = prev + 1;
    end
    last_c = done_c + 1;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      ov = (ovi < n_ov) && (ov_c[ovi] == c);
      if (abort >= 0 && c == abort + 1) ov = 1'b0;
      acc_ovalid = ov;
      rst = !(c == abort);
      if (c == 0) begin
        start = 1'b1;
        num_rows = 8'(r);
        num_chunks = 8'(ch);
      end else begin
        start = noise && (c <= done_c) && ($urandom_range(0, 1) == 1);
        if (noise) begin
          num_rows = 8'($urandom);
          num_chunks = 8'($urandom);
        end
      end
      @(negedge clk);
      if (abort >= 0 && c == abort + 1) begin
        chk_zero("abort");
        break;
      end
      if (c >= 1) begin
        chk("busy", 32'(busy), 32'(c <= done_c));
        chk("done", 32'(done), 32'(c == done_c));
        if (c <= rc) begin
          chk("vec_raddr", 32'(vec_raddr), 32'((c - 1) % ch));
          chk("mat_raddr", 32'(mat_raddr), 32'(c - 1));
        end
        k = c - LAT;
        iv = (k >= 1) && (k <= rc);
        chk("acc_ivalid", 32'(acc_ivalid), 32'(iv));
        chk("acc_first", 32'(acc_first), iv ? 32'(((k - 1) % ch) == 0) : 0);
        chk("acc_last", 32'(acc_last), iv ? 32'(((k - 1) % ch) == ch - 1) : 0);
        chk("res_valid", 32'(res_valid), 32'(ov));
        if (ov) begin
          chk("res_row", 32'(res_row), 32'(ovi));
          ovi++;
        end
`ifdef MVM_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, 32'((c - 1 < done_c) ? c - 1 : done_c));
`endif
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    acc_ovalid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    acc_ovalid = 1'b0;
    num_rows = '0;
    num_chunks = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run(3, 4, 1'b0, 1'b0, -1);

    // Result pulses while idle must be ignored; the next run's first res_row proves the count held.
    for (int i = 0; i < 3; i++) begin
      acc_ovalid = 1'b1;
      @(negedge clk);
      chk("idle_res_valid", 32'(res_valid), 0);
      chk("idle_busy", 32'(busy), 0);
`ifdef MVM_CTRL_PERF_EN
      chk("idle_perf_hold", perf_cycles, 18);
`endif
      @(posedge clk); #1;
    end
    acc_ovalid = 1'b0;

    run(2, 1, 1'b0, 1'b0, -1);
    run(0, 5, 1'b0, 1'b0, -1);
    run(4, 0, 1'b0, 1'b0, -1);
    run(3, 4, 1'b0, 1'b1, -1);
    run(3, 4, 1'b0, 1'b0, 7);
    run(3, 4, 1'b0, 1'b0, -1);
    for (int n = 0; n < 8; n++) begin
      run(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), 1'b1, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mvm_ctrl.md
Name: mvm_ctrl

Overview:
Sequencer for the matrix-vector multiply datapath. Takes a start command with row/chunk counts, steps matrix and vector memory read addresses one chunk per cycle, and delays valid/first/last tags so they reach the accumulator aligned with the dot-product data. Counts accumulator result pulses, tags each result with its row index, and pulses done when the last row has completed.

Parameters:
ROWW, 8, width of row count / row index
CHUNKW, 8, width of chunks-per-row count / vector address
MAT_ADDRW, 16, matrix memory address width
PIPE_LAT, 4, cycles from address issue to data at accumulator input (memory read + dot-product pipeline); legal values ≥1

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
start  input  1  start pulse; sampled only in IDLE
num_rows  input  ROWW  rows to process; latched on accepted start
num_chunks  input  CHUNKW  chunks per row; latched on accepted start
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
vec_raddr  output  CHUNKW  vector memory read address
mat_raddr  output  MAT_ADDRW  matrix memory read address
acc_ivalid  output  1  accumulator input valid
acc_first  output  1  first chunk of a row
acc_last  output  1  last chunk of a row
acc_ovalid  input  1  accumulator result-valid pulse
res_row  output  ROWW  row index of the current acc_ovalid
res_valid  output  1  equals acc_ovalid while in ISSUE or DRAIN; 0 otherwise

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; counters and tag pipe cleared; busy, done, acc_ivalid, acc_first, acc_last = 0; vec_raddr, mat_raddr, res_row = 0. Reset mid-operation aborts at once; in-flight tags are discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, latch num_rows and num_chunks, clear counters. If either value is 0, go to DONE. Otherwise go to ISSUE.
- ISSUE: one chunk issued per cycle, registered outputs.
  - vec_raddr = chunk index (0..num_chunks-1).
  - mat_raddr = running linear count starting at 0, +1 per issue; wraps modulo 2^MAT_ADDRW with no error.
  - Tag for each issue: first = (chunk==0), last = (chunk==num_chunks-1).
  - After the last chunk of the last row, go to DRAIN.
- Tag pipe: PIPE_LAT-deep shift register. An issue in cycle t drives acc_ivalid/acc_first/acc_last in cycle t+PIPE_LAT. Empty slots carry ivalid=0. num_chunks=1 gives first=last=1 on the same beat.
- Result tracking:
  - Each acc_ovalid in ISSUE or DRAIN outputs res_row = completed-row count (combinational from count register), then increments the count.
  - acc_ovalid in IDLE or DONE is ignored.
  - ovalid arriving in the same cycle as the ISSUE→DRAIN transition is counted.
- DRAIN: wait until completed count == num_rows, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in ISSUE, DRAIN and DONE.
- start outside IDLE is ignored. Input changes after an accepted start do not affect the run.

Optional Feature:
MVM_CTRL_PERF_EN
- Defined: adds output perf_cycles (32 bits). Cleared on an accepted start, +1 each cycle while busy (saturates at all-ones), holds its value after DONE until the next accepted start. Reset value 0.
- Undefined: perf_cycles port and its logic are absent.

Test Plan:
- Basic run: PIPE_LAT=4, num_rows=3, num_chunks=4, start in cycle 0.
  - Issue cycles 1–12; mat_raddr 0..11; vec_raddr 0,1,2,3 repeating.
  - acc_ivalid cycles 5–16; acc_first at 5, 9, 13; acc_last at 8, 12, 16.
  - Bench returns acc_ovalid at 9, 13, 17 → res_row 0, 1, 2; done at 18; busy 1→18.
- Single chunk: num_rows=2, num_chunks=1 → acc_ivalid at cycles 5 and 6, each beat with first=last=1; done follows the second ovalid.
- Zero size: num_rows=0 (then separately num_chunks=0) → done in cycle 1, no acc_ivalid, busy high only in cycle 1.
- Ignored inputs: start pulses during ISSUE, and acc_ovalid in IDLE → no restart, no res_valid, counts unchanged.
- Reset abort: rst=0 at cycle 7 of the basic run → next cycle all outputs 0, IDLE. A new start then runs cleanly from mat_raddr 0.
- With MVM_CTRL_PERF_EN: perf_cycles=18 after the basic run, stable until the next start. A 0-row run gives perf_cycles=1.
